dcache_ram_sequencer: RTL and testbench

- Owns one dcache data array: four 32x8 single-port RAM byte lanes, combinational read, write on clk.
- Shares that array between three requesters: the CPU load/store port, the line-refill port from the memory side, and a whole-array clear request.
- Sequences all three with one FSM. The RAM port is driven only by this block.

---
 rtl/dcache_ram_sequencer_pkg.sv | 12 +
 rtl/dcache_ram_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dcache_ram_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ram_sequencer_pkg.sv
// Shared dcache definitions: sequencer state encoding and data-array lane geometry.
package dcache_ram_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CPU   = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

endpackage

// File: rtl/dcache_ram_sequencer.sv
// Single owner of the dcache data array port: arbitrates clear, line refill and CPU
// load/store onto one shared RAM address/write bus with a four-state FSM.
module dcache_ram_sequencer
    import dcache_ram_sequencer_pkg::*;
#(
    parameter  int ADDRBITS  = 5,
    parameter  int LINEWORDS = 8,
    localparam int LINEBITS  = ADDRBITS - $clog2(LINEWORDS)
) (
    input  logic                       clk,
    input  logic                       reset_n,

    input  logic                       cpu_req,
    input  logic                       cpu_wr,
    input  logic [ADDRBITS-1:0]        cpu_addr,
    input  logic [LANES*LANE_W-1:0]    cpu_wdata,
    input  logic [LANES-1:0]           cpu_bytemask,
    output logic [LANES*LANE_W-1:0]    cpu_rdata,
    output logic                       cpu_ack,

    input  logic                       fill_req,
    input  logic [LINEBITS-1:0]        fill_line,
    input  logic [LANES*LANE_W-1:0]    fill_data,
    input  logic                       fill_valid,
    output logic                       fill_ready,
    output logic                       fill_done,

    input  logic                       clr_req,
    output logic                       clr_done,

    output logic [ADDRBITS-1:0]        ram_addr,
    output logic [LANES-1:0]           ram_we,
    output logic [LANES*LANE_W-1:0]    ram_wdata,
    input  logic [LANES*LANE_W-1:0]    ram_rdata
);

    localparam int WORDW = LANES * LANE_W;
    localparam int LWB   = $clog2(LINEWORDS);

    localparam logic [ADDRBITS-1:0] CNT_LAST  = '1;
    localparam logic [LWB-1:0]      WORD_LAST = LWB'(LINEWORDS - 1);

    logic [1:0]            r_state;
    logic [ADDRBITS-1:0]   r_cnt;
    logic [ADDRBITS-1:0]   r_addr;
    logic                  r_wr;
    logic [WORDW-1:0]      r_wdata;
    logic [LANES-1:0]      r_mask;
    logic [LINEBITS-1:0]   r_line;
    logic [WORDW-1:0]      r_rdata;
    logic                  r_ack;
    logic                  r_fill_done;
    logic                  r_clr_done;

    logic [ADDRBITS-1:0]   w_fill_addr;
    logic                  w_fill_last;

    // The shared counter walks words within a line during FILL and the whole array during CLEAR.
    assign w_fill_addr = {r_line, r_cnt[LWB-1:0]};
    assign w_fill_last = (r_cnt[LWB-1:0] == WORD_LAST);

    assign cpu_rdata = r_rdata;
    assign cpu_ack   = r_ack;
    assign fill_done = r_fill_done;
    assign clr_done  = r_clr_done;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        ram_addr   = '0;
        ram_we     = '0;
        ram_wdata  = '0;
        fill_ready = 1'b0;
        case (r_state)
            ST_CPU: begin
                ram_addr = r_addr;
                if (r_wr) begin
                    ram_we    = r_mask;
                    ram_wdata = r_wdata;
                end
            end
            ST_FILL: begin
                fill_ready = 1'b1;
                ram_addr   = w_fill_addr;
                ram_wdata  = fill_data;
                ram_we     = fill_valid ? '1 : '0;
            end
            ST_CLEAR: begin
                ram_addr = r_cnt;
                ram_we   = '1;
            end
            default: ;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_line      <= '0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
            r_fill_done <= 1'b0;
            r_clr_done  <= 1'b0;
        end else begin
            r_ack       <= 1'b0;
            r_fill_done <= 1'b0;
            r_clr_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end else if (fill_req) begin
                        r_state <= ST_FILL;
                        r_line  <= fill_line;
                        r_cnt   <= '0;
                    end else if (cpu_req) begin
                        r_state <= ST_CPU;
                        r_addr  <= cpu_addr;
                        r_wr    <= cpu_wr;
                        r_wdata <= cpu_wdata;
                        r_mask  <= cpu_bytemask;
                    end
                end
                ST_CPU: begin
                    // On a store this captures the pre-write contents of the addressed word.
                    r_rdata <= ram_rdata;
                    r_ack   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_FILL: begin
                    if (fill_valid) begin
                        if (w_fill_last) begin
                            r_cnt       <= '0;
                            r_fill_done <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + ADDRBITS'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt      <= '0;
                        r_clr_done <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + ADDRBITS'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ram_sequencer.sv
// Directed bench for dcache_ram_sequencer with a behavioural four-lane data array on the RAM port.
module tb_dcache_ram_sequencer;

    logic        clk;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_wr;
    logic [4:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_bytemask;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        fill_req;
    logic [1:0]  fill_line;
    logic [31:0] fill_data;
    logic        fill_valid;
    logic        fill_ready;
    logic        fill_done;
    logic        clr_req;
    logic        clr_done;
    logic [4:0]  ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int tests_run;
    int tests_failed;

    logic [31:0] mem [32];

    dcache_ram_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_req      (cpu_req),
        .cpu_wr       (cpu_wr),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_bytemask (cpu_bytemask),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .fill_req     (fill_req),
        .fill_line    (fill_line),
        .fill_data    (fill_data),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_done    (fill_done),
        .clr_req      (clr_req),
        .clr_done     (clr_done),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-lane array: combinational read, per-lane write on the rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
    assign ram_rdata = mem[ram_addr];

    // Issues one CPU access from the post-edge region and waits (bounded) for its ack.
    task automatic cpu_access(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                              input logic [3:0] mask, output logic [31:0] rdata, output int lat,
                              output logic [3:0] we1, output logic [4:0] addr1);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_bytemask = mask;
        lat = 0; we1 = '0; addr1 = '0; rdata = '0;
        while (lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin we1 = ram_we; addr1 = ram_addr; end
            if (cpu_ack) begin rdata = cpu_rdata; break; end
        end
        cpu_req = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({cpu_ack, fill_ready, fill_done, clr_done} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_flags: got %b expected 0000", {cpu_ack, fill_ready, fill_done, clr_done});
        end
        tests_run++;
        if (cpu_rdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_rdata: got %h expected 00000000", cpu_rdata);
        end
        tests_run++;
        if ({ram_addr, ram_we} !== 9'h0) begin
            tests_failed++; $display("FAIL reset_ram_ctl: got addr %h we %h expected 0", ram_addr, ram_we);
        end
        tests_run++;
        if (ram_wdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_wdata: got %h expected 00000000", ram_wdata);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; int lat; logic [3:0] we1; logic [4:0] a1;
        cpu_access(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, rd, lat, we1, a1);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("FAIL store_latency: got %0d expected 2", lat); end
        tests_run++;
        if ({we1, a1} !== {4'hF, 5'd5}) begin
            tests_failed++; $display("FAIL store_ram_port: got we %h addr %0d expected we f addr 5", we1, a1);
        end
        cpu_access(1'b0, 5'd5, 32'h0, 4'h0, rd, lat, we1, a1);
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("FAIL load_latency: got %0d expected 2", lat); end
        tests_run++;
        if (we1 !== 4'h0) begin tests_failed++; $display("FAIL load_no_write: got we %h expected 0", we1); end
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL load_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; int lat; logic [3:0] we1; logic [4:0] a1;
        cpu_access(1'b1, 5'd5, 32'h11223344, 4'b0101, rd, lat, we1, a1);
        tests_run++;
        if (we1 !== 4'b0101) begin tests_failed++; $display("FAIL partial_we: got %b expected 0101", we1); end
        tests_run++;
        if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL store_prewrite_rdata: got %h expected deadbeef", rd); end
        cpu_access(1'b0, 5'd5, 32'h0, 4'h0, rd, lat, we1, a1);
        tests_run++;
        if (rd !== 32'hDE22BE44) begin tests_failed++; $display("FAIL partial_merge: got %h expected de22be44", rd); end
    endtask

    task automatic test_fill();
        int idx, cyc, bad, early, lat; logic tog; logic [31:0] rd; logic [3:0] we1; logic [4:0] a1;
        fill_req = 1'b1; fill_line = 2'd2; fill_valid = 1'b0; fill_data = '0;
        @(posedge clk); #1;
        tests_run++;
        if (fill_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_ready_on: got %b expected 1", fill_ready); end
        idx = 0; cyc = 0; bad = 0; early = 0; tog = 1'b0;
        while (idx < 8 && cyc < 64) begin
            fill_valid = tog; fill_data = 32'hA0 + idx;
            #1;
            if (tog) begin
                if (ram_we !== 4'hF || ram_addr !== 5'(16 + idx) || ram_wdata !== 32'hA0 + idx) bad++;
            end else if (ram_we !== 4'h0) bad++;
            @(posedge clk); #1;
            if (tog) idx++;
            tog = ~tog; cyc++;
            if (idx < 8 && fill_done) early++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL fill_write_pattern: got %0d bad cycles expected 0", bad); end
        tests_run++;
        if ({idx, cyc} !== {32'd8, 32'd16}) begin
            tests_failed++; $display("FAIL fill_cycles: got %0d words in %0d cycles expected 8 in 16", idx, cyc);
        end
        tests_run++;
        if ({early, fill_done, fill_ready} !== {32'd0, 1'b1, 1'b0}) begin
            tests_failed++; $display("FAIL fill_done_pulse: got early %0d done %b ready %b expected 0 1 0", early, fill_done, fill_ready);
        end
        fill_req = 1'b0; fill_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (fill_done !== 1'b0) begin tests_failed++; $display("FAIL fill_done_single: got %b expected 0", fill_done); end
        cpu_access(1'b0, 5'd16, 32'h0, 4'h0, rd, lat, we1, a1);
        tests_run++;
        if (rd !== 32'hA0) begin tests_failed++; $display("FAIL fill_word0: got %h expected 000000a0", rd); end
        cpu_access(1'b0, 5'd23, 32'h0, 4'h0, rd, lat, we1, a1);
        tests_run++;
        if (rd !== 32'hA7) begin tests_failed++; $display("FAIL fill_word7: got %h expected 000000a7", rd); end
    endtask

    task automatic test_priority();
        int c, t_clr, t_fill, t_ack, n_clear, n_clr_done, widx, lat;
        logic pend; logic [31:0] rd, rd2; logic [3:0] we1; logic [4:0] a1;
        clr_req = 1'b1; fill_req = 1'b1; fill_line = 2'd1;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd9;
        c = 0; t_clr = 0; t_fill = 0; t_ack = 0; n_clear = 0; n_clr_done = 0; widx = 0; pend = 1'b0; rd = '0;
        while (c < 120 && t_ack == 0) begin
            @(posedge clk); #1;
            c++;
            if (pend) widx++;
            if (ram_we == 4'hF && !fill_ready) n_clear++;
            if (clr_done) begin n_clr_done++; if (t_clr == 0) t_clr = c; clr_req = 1'b0; end
            if (fill_done) begin t_fill = c; fill_req = 1'b0; end
            if (cpu_ack) begin t_ack = c; rd = cpu_rdata; cpu_req = 1'b0; end
            if (fill_ready) begin fill_valid = 1'b1; fill_data = 32'hB0 + widx; pend = 1'b1; end
            else begin fill_valid = 1'b0; pend = 1'b0; end
        end
        cpu_req = 1'b0; fill_req = 1'b0; clr_req = 1'b0; fill_valid = 1'b0;
        tests_run++;
        if ({n_clear, n_clr_done} !== {32'd32, 32'd1}) begin
            tests_failed++; $display("FAIL clear_length: got %0d writes %0d done expected 32 writes 1 done", n_clear, n_clr_done);
        end
        tests_run++;
        if ({t_clr, t_fill, t_ack} !== {32'd33, 32'd42, 32'd44}) begin
            tests_failed++; $display("FAIL priority_order: got clr %0d fill %0d ack %0d expected 33 42 44", t_clr, t_fill, t_ack);
        end
        tests_run++;
        if (rd !== 32'hB1) begin tests_failed++; $display("FAIL priority_cpu_data: got %h expected 000000b1", rd); end
        cpu_access(1'b0, 5'd5, 32'h0, 4'h0, rd2, lat, we1, a1);
        tests_run++;
        if (rd2 !== 32'h0) begin tests_failed++; $display("FAIL clear_zeroed: got %h expected 00000000", rd2); end
    endtask

    task automatic test_reset_mid_fill();
        int n_done, lat; logic [31:0] rd; logic [3:0] we1; logic [4:0] a1;
        n_done = 0;
        fill_req = 1'b1; fill_line = 2'd3; fill_valid = 1'b1; fill_data = 32'hC0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            fill_data = 32'hC0 + i;
            @(posedge clk); #1;
            if (fill_done) n_done++;
        end
        tests_run++;
        if (ram_addr !== 5'd27) begin tests_failed++; $display("FAIL midfill_position: got addr %0d expected 27", ram_addr); end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({fill_ready, fill_done, cpu_ack, clr_done, ram_we, ram_addr} !== 13'h0) begin
            tests_failed++; $display("FAIL midfill_reset_outputs: got ready %b we %h addr %0d expected all 0", fill_ready, ram_we, ram_addr);
        end
        fill_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (fill_done) n_done++; end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({fill_ready, ram_addr} !== {1'b1, 5'd24}) begin
            tests_failed++; $display("FAIL refill_restart: got ready %b addr %0d expected 1 24", fill_ready, ram_addr);
        end
        for (int i = 0; i < 8; i++) begin
            fill_valid = 1'b1; fill_data = 32'hD0 + i;
            @(posedge clk); #1;
            if (fill_done && i < 7) n_done++;
        end
        tests_run++;
        if ({n_done, fill_done} !== {32'd0, 1'b1}) begin
            tests_failed++; $display("FAIL refill_done: got spurious %0d done %b expected 0 1", n_done, fill_done);
        end
        fill_req = 1'b0; fill_valid = 1'b0;
        @(posedge clk); #1;
        cpu_access(1'b0, 5'd27, 32'h0, 4'h0, rd, lat, we1, a1);
        tests_run++;
        if (rd !== 32'hD3) begin tests_failed++; $display("FAIL refill_word3: got %h expected 000000d3", rd); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat; int nack, bad;
        pat = '0; nack = 0; bad = 0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd24;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            pat[c] = cpu_ack;
            if (cpu_ack) begin nack++; if (cpu_rdata !== 32'hD0) bad++; end
        end
        cpu_req = 1'b0;
        tests_run++;
        if (pat !== 6'b101010) begin tests_failed++; $display("FAIL b2b_ack_pattern: got %b expected 101010", pat); end
        tests_run++;
        if ({nack, bad} !== {32'd3, 32'd0}) begin
            tests_failed++; $display("FAIL b2b_ack_data: got %0d acks %0d bad expected 3 acks 0 bad", nack, bad);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (cpu_ack !== 1'b0) begin tests_failed++; $display("FAIL b2b_quiet: got ack %b expected 0", cpu_ack); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_bytemask = '0;
        fill_req = 1'b0; fill_line = '0; fill_data = '0; fill_valid = 1'b0; clr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        test_store_load();
        test_partial_store();
        test_fill();
        test_priority();
        test_reset_mid_fill();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
